// File: rtl/bt_len_ctrl.sv
// Sequencing controller for the bitmap length unit: issues one bitmap word at a time,
// captures cumulative lengths and tracks the block base offset. Optional overflow flag: BT_LEN_CTRL_OVF_EN.
module bt_len_ctrl #(
  parameter int BASE_W = 16
) (
  input  logic              aclk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_bitmap,
  input  logic              s_last,
  output logic [15:0]       bt_bitmap,
  input  logic [79:0]       bt_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BASE_W-1:0] m_base,
  output logic [79:0]       m_len,
  output logic [9:0]        m_total,
  output logic              m_last,
  output logic              ovf_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, OUT} state_t;

  state_t             state_q, state_d;
  logic [15:0]        bitmap_q, bitmap_d;
  logic               last_q, last_d;
  logic [BASE_W-1:0]  base_q, base_d;
  logic [BASE_W-1:0]  m_base_q, m_base_d;
  logic [79:0]        m_len_q, m_len_d;
  logic [9:0]         m_total_q, m_total_d;
  logic               m_last_q, m_last_d;
  logic               m_valid_q, m_valid_d;

  // Base plus this word's total, one bit wider so the carry is visible.
  logic [BASE_W:0]    base_sum;
  assign base_sum = {1'b0, base_q} + (BASE_W + 1)'(m_total_q);

`ifdef BT_LEN_CTRL_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d   = state_q;
    bitmap_d  = bitmap_q;
    last_d    = last_q;
    base_d    = base_q;
    m_base_d  = m_base_q;
    m_len_d   = m_len_q;
    m_total_d = m_total_q;
    m_last_d  = m_last_q;
`ifdef BT_LEN_CTRL_OVF_EN
    ovf_d     = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          bitmap_d = s_bitmap;
          last_d   = s_last;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = CAPT;
      CAPT: begin
        m_len_d   = bt_len;
        m_total_d = bt_len[79:70];
        m_last_d  = last_q;
        m_base_d  = base_q;
        state_d   = OUT;
      end
      OUT: begin
        if (m_ready) begin
          if (last_q) begin
            base_d = '0;
          end else begin
            base_d = base_sum[BASE_W-1:0];
`ifdef BT_LEN_CTRL_OVF_EN
            if (base_sum[BASE_W]) ovf_d = 1'b1;
`endif
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    m_valid_d = (state_d == OUT);
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      bitmap_q  <= '0;
      last_q    <= 1'b0;
      base_q    <= '0;
      m_base_q  <= '0;
      m_len_q   <= '0;
      m_total_q <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
`ifdef BT_LEN_CTRL_OVF_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bitmap_q  <= bitmap_d;
      last_q    <= last_d;
      base_q    <= base_d;
      m_base_q  <= m_base_d;
      m_len_q   <= m_len_d;
      m_total_q <= m_total_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
`ifdef BT_LEN_CTRL_OVF_EN
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign s_ready   = (state_q == IDLE);
  assign bt_bitmap = bitmap_q;
  assign m_valid   = m_valid_q;
  assign m_base    = m_base_q;
  assign m_len     = m_len_q;
  assign m_total   = m_total_q;
  assign m_last    = m_last_q;
`ifdef BT_LEN_CTRL_OVF_EN
  assign ovf_err   = ovf_q;
`else
  assign ovf_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bt_len_ctrl.sv
// Bench for bt_len_ctrl: behavioural length unit, table of words, scoreboard of expected results.
module tb_bt_len_ctrl;
  localparam int BW = 10;
`ifdef BT_LEN_CTRL_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_bitmap = '0;
  logic          s_last = 1'b0;
  logic [15:0]   bt_bitmap;
  logic [79:0]   bt_len = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [BW-1:0] m_base;
  logic [79:0]   m_len;
  logic [9:0]    m_total;
  logic          m_last;
  logic          ovf_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  bt_len_ctrl #(.BASE_W(BW)) dut (
    .aclk(aclk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_bitmap(s_bitmap), .s_last(s_last), .bt_bitmap(bt_bitmap), .bt_len(bt_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_base(m_base), .m_len(m_len),
    .m_total(m_total), .m_last(m_last), .ovf_err(ovf_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [79:0] cum(input logic [15:0] bm);
    logic [79:0] r;
    logic [9:0]  acc;
    r = '0;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      case (bm[2*i +: 2])
        2'b00: acc = acc + 10'd0;
        2'b01: acc = acc + 10'd8;
        2'b10: acc = acc + 10'd16;
        default: acc = acc + 10'd32;
      endcase
      r[10*i +: 10] = acc;
    end
    return r;
  endfunction

  // Registered length unit: output follows bt_bitmap one cycle later.
  always @(posedge aclk) bt_len <= cum(bt_bitmap);

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [BW-1:0] base;
    logic [79:0]   len;
    logic [9:0]    total;
    logic          last;
  } exp_t;
  exp_t sb[$];

  // Scoreboard: compare each result on the cycle its handshake completes.
  always @(negedge aclk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 80'd1, 80'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("m_base", 80'(m_base), 80'(e.base));
        chk("m_len", m_len, e.len);
        chk("m_total", 80'(m_total), 80'(e.total));
        chk("m_last", 80'(m_last), 80'(e.last));
        $display("result base=%0d total=%0d last=%0d", m_base, m_total, m_last);
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic send(input logic [15:0] bm, input logic lst,
                      input logic [BW-1:0] eb, input logic [9:0] et);
    int t;
    exp_t e;
    t = 0;
    while (!s_ready && t < 200) begin tick(); t++; end
    if (t >= 200) chk("s_ready_timeout", 80'd0, 80'd1);
    e.base = eb; e.len = cum(bm); e.total = et; e.last = lst;
    sb.push_back(e);
    s_valid = 1'b1; s_bitmap = bm; s_last = lst;
    tick();
    s_valid = 1'b0;
    $display("send bitmap=0x%04h last=%0d exp_base=%0d exp_total=%0d", bm, lst, eb, et);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin tick(); t++; end
    if (t >= 400) chk("drain_timeout", 80'(sb.size()), 80'd0);
  endtask

  typedef struct {
    logic [15:0]   bm;
    logic          last;
    logic [BW-1:0] base;
    logic [9:0]    total;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{16'h5555, 1'b1, 10'd0,   10'd64};
    vecs[1] = '{16'hFFFF, 1'b0, 10'd0,   10'd256};
    vecs[2] = '{16'h0000, 1'b0, 10'd256, 10'd0};
    vecs[3] = '{16'hAAAA, 1'b1, 10'd256, 10'd128};
    vecs[4] = '{16'h1B1B, 1'b0, 10'd0,   10'd112};
    vecs[5] = '{16'h0001, 1'b1, 10'd112, 10'd8};

    tick(); tick();
    rst = 1'b0;
    chk("rst_m_valid", 80'(m_valid), 80'd0);
    chk("rst_s_ready", 80'(s_ready), 80'd1);
    chk("rst_m_base", 80'(m_base), 80'd0);
    chk("rst_m_len", m_len, 80'd0);
    chk("rst_m_total", 80'(m_total), 80'd0);
    chk("rst_m_last", 80'(m_last), 80'd0);
    chk("rst_ovf", 80'(ovf_err), 80'd0);
    chk("rst_bt_bitmap", 80'(bt_bitmap), 80'd0);

    // First word: latency and s_ready timing by hand.
    m_ready = 1'b1;
    send(vecs[0].bm, vecs[0].last, vecs[0].base, vecs[0].total);
    chk("s_ready_drop", 80'(s_ready), 80'd0);
    chk("m_valid_e0", 80'(m_valid), 80'd0);
    tick();
    chk("m_valid_e1", 80'(m_valid), 80'd0);
    tick();
    chk("m_valid_e2", 80'(m_valid), 80'd1);
    chk("len_5555_e0", 80'(m_len[9:0]), 80'd8);
    chk("len_5555_e7", 80'(m_len[79:70]), 80'd64);
    tick();
    chk("s_ready_return", 80'(s_ready), 80'd1);
    chk("m_valid_clear", 80'(m_valid), 80'd0);

    for (int i = 1; i < 6; i++) begin
      send(vecs[i].bm, vecs[i].last, vecs[i].base, vecs[i].total);
      if (vecs[i].bm == 16'h1B1B) begin
        tick(); tick();
        chk("mix_e1", 80'(m_len[19:10]), 80'd48);
        chk("mix_e3", 80'(m_len[39:30]), 80'd56);
        chk("mix_e5", 80'(m_len[59:50]), 80'd104);
      end
    end
    wait_drain();

    // Stall in OUT for 5 cycles.
    m_ready = 1'b0;
    send(16'h0101, 1'b0, 10'd0, 10'd16);
    tick(); tick();
    for (int c = 0; c < 5; c++) begin
      chk("stall_m_valid", 80'(m_valid), 80'd1);
      chk("stall_s_ready", 80'(s_ready), 80'd0);
      chk("stall_m_base", 80'(m_base), 80'd0);
      chk("stall_m_total", 80'(m_total), 80'd16);
      tick();
    end
    m_ready = 1'b1;
    wait_drain();
    send(16'h0001, 1'b1, 10'd16, 10'd8);
    wait_drain();

    // Base wrap across four full words.
    for (int i = 0; i < 3; i++) send(16'hFFFF, 1'b0, BW'(256 * i), 10'd256);
    wait_drain();
    chk("ovf_before", 80'(ovf_err), 80'd0);
    send(16'hFFFF, 1'b0, 10'd768, 10'd256);
    wait_drain();
    chk("ovf_after", 80'(ovf_err), 80'(OVF_EXP));
    send(16'h0001, 1'b1, 10'd0, 10'd8);
    wait_drain();

    // Reset with a word in CAPT.
    send(16'hFFFF, 1'b0, 10'd0, 10'd256);
    wait_drain();
    s_valid = 1'b1; s_bitmap = 16'h5555; s_last = 1'b0;
    tick();
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_m_valid", 80'(m_valid), 80'd0);
    chk("mid_rst_s_ready", 80'(s_ready), 80'd1);
    chk("mid_rst_ovf", 80'(ovf_err), 80'd0);
    chk("mid_rst_m_total", 80'(m_total), 80'd0);
    send(16'h0001, 1'b1, 10'd0, 10'd8);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
